// File: rtl/tube_readout.sv
// ============================================================================
//  Module   : tube_readout
//  Purpose  : Serialises one captured drift-tube event into (tube, time) words
//             for the RPi RD_CLK/RD_EN/RD_EMPTY/RD_VALID read handshake.
//  Options  : TUBE_READOUT_TRAILER_EN - append (0xFF, hit count) trailer word
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tube_readout #(
  parameter int NTUBES      = 32,
  parameter int TW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk100,
  input  logic                   rst,
  input  logic                   evt_valid,
  input  logic [0:NTUBES*TW-1]   evt_times,
  output logic                   evt_busy,
  output logic [7:0]             drop_cnt,
  output logic [0:7]             OTUBEN,
  output logic [0:7]             OTUBER,
  input  logic                   RD_CLK,
  input  logic                   RD_EN,
  output logic                   RD_EMPTY,
  output logic                   RD_VALID
);

  localparam int              c_IW       = (NTUBES > 1) ? $clog2(NTUBES) : 1;
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NTUBES - 1);
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SCAN  = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;

  // RPi pin synchronisers and read-strobe edge detector
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_clk_prev;
  logic                   r_strobe;

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_en_sync  <= '0;
      r_clk_prev <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], RD_CLK};
      r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], RD_EN};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      r_strobe   <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev & r_en_sync[SYNC_STAGES-1];
    end
  end

  // Hit mask of the incoming event
  logic [NTUBES-1:0] w_hit;

  for (genvar gi = 0; gi < NTUBES; gi++) begin : g_hit
    assign w_hit[gi] = (evt_times[TW*gi +: TW] != {TW{1'b1}});
  end

  logic [1:0]           r_state;
  logic [0:NTUBES*TW-1] r_times;
  logic [NTUBES-1:0]    r_pend;
  logic [c_IW-1:0]      r_idx;
  logic                 r_busy;
  logic                 r_empty;
  logic                 r_valid;
  logic [7:0]           r_tuben;
  logic [7:0]           r_tuber;
  logic [7:0]           r_drop;

  logic [TW-1:0]        w_time_sel;
  logic [NTUBES-1:0]    w_idx_onehot;

  assign w_time_sel   = r_times[TW*r_idx +: TW];
  assign w_idx_onehot = NTUBES'(1) << r_idx;

`ifdef TUBE_READOUT_TRAILER_EN
  logic       r_trl;
  logic [7:0] r_hit_cnt;

  function automatic logic [7:0] f_popcount(input logic [NTUBES-1:0] m);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < NTUBES; i++) begin
      cnt = cnt + 8'(m[i]);
    end
    return cnt;
  endfunction
`endif

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_times <= '1;
      r_pend  <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
      r_tuben <= 8'd0;
      r_tuber <= 8'd0;
`ifdef TUBE_READOUT_TRAILER_EN
      r_trl     <= 1'b0;
      r_hit_cnt <= 8'd0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (evt_valid && (|w_hit)) begin
            r_times <= evt_times;
            r_pend  <= w_hit;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_empty <= 1'b0;
            r_state <= c_SCAN;
`ifdef TUBE_READOUT_TRAILER_EN
            r_hit_cnt <= f_popcount(w_hit);
`endif
          end
        end

        c_SCAN: begin
          if (r_pend[r_idx]) begin
            r_tuben <= 8'(r_idx);
            r_tuber <= 8'(w_time_sel);
            r_valid <= 1'b1;
            r_state <= c_READY;
          end else if (r_idx == c_LAST_IDX) begin
`ifdef TUBE_READOUT_TRAILER_EN
            r_tuben <= 8'hFF;
            r_tuber <= r_hit_cnt;
            r_valid <= 1'b1;
            r_trl   <= 1'b1;
            r_state <= c_READY;
`else
            r_busy  <= 1'b0;
            r_state <= c_IDLE;
`endif
          end else begin
            r_idx <= r_idx + c_IDX_ONE;
          end
        end

        c_READY: begin
          if (r_strobe) begin
            r_valid <= 1'b0;
`ifdef TUBE_READOUT_TRAILER_EN
            if (r_trl) begin
              r_trl   <= 1'b0;
              r_busy  <= 1'b0;
              r_empty <= 1'b1;
              r_state <= c_IDLE;
            end else begin
              r_pend <= r_pend & ~w_idx_onehot;
              // Last tube re-enters SCAN at the same index so it falls through to the trailer
              if (r_idx != c_LAST_IDX) begin
                r_idx <= r_idx + c_IDX_ONE;
              end
              r_state <= c_SCAN;
            end
`else
            r_pend  <= r_pend & ~w_idx_onehot;
            r_empty <= ((r_pend & ~w_idx_onehot) == '0);
            if (r_idx == c_LAST_IDX) begin
              r_busy  <= 1'b0;
              r_state <= c_IDLE;
            end else begin
              r_idx   <= r_idx + c_IDX_ONE;
              r_state <= c_SCAN;
            end
`endif
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Busy is the registered flag, so an event arriving as busy clears is still dropped
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_drop <= 8'd0;
    end else if (evt_valid && r_busy && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign evt_busy = r_busy;
  assign drop_cnt = r_drop;
  assign OTUBEN   = r_tuben;
  assign OTUBER   = r_tuber;
  assign RD_EMPTY = r_empty;
  assign RD_VALID = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_tube_readout.sv
// ============================================================================
//  Module   : tb_tube_readout
//  Purpose  : Scoreboard bench for tube_readout; a monitor pops one expected
//             word each time RD_VALID rises.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tube_readout;

  localparam int NT = 32;
  localparam int TW = 8;

  logic              clk100    = 1'b0;
  logic              rst       = 1'b1;
  logic              evt_valid = 1'b0;
  logic [0:NT*TW-1]  evt_times = '1;
  logic              RD_CLK    = 1'b0;
  logic              RD_EN     = 1'b0;
  logic              evt_busy;
  logic [7:0]        drop_cnt;
  logic [0:7]        OTUBEN;
  logic [0:7]        OTUBER;
  logic              RD_EMPTY;
  logic              RD_VALID;

  tube_readout #(.NTUBES(NT), .TW(TW), .SYNC_STAGES(2)) dut (
    .clk100    (clk100),
    .rst       (rst),
    .evt_valid (evt_valid),
    .evt_times (evt_times),
    .evt_busy  (evt_busy),
    .drop_cnt  (drop_cnt),
    .OTUBEN    (OTUBEN),
    .OTUBER    (OTUBER),
    .RD_CLK    (RD_CLK),
    .RD_EN     (RD_EN),
    .RD_EMPTY  (RD_EMPTY),
    .RD_VALID  (RD_VALID)
  );

  always #5 clk100 = ~clk100;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] r;
  } word_t;

  word_t            exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [0:NT*TW-1] ev;
  logic             prev_v  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh word must match the head of the scoreboard
  always @(negedge clk100) begin
    word_t w;
    if (RD_VALID && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h/%0h expected none", OTUBEN, OTUBER);
      end else begin
        w = exp_q.pop_front();
        check("word_tuben", 32'(OTUBEN), 32'(w.n));
        check("word_tuber", 32'(OTUBER), 32'(w.r));
      end
    end
    prev_v = RD_VALID;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic clr_ev();
    ev = '1;
  endtask

  task automatic set_hit(input int t, input logic [7:0] v);
    ev[TW*t +: TW] = v;
  endtask

  task automatic push(input logic [7:0] n, input logic [7:0] r);
    exp_q.push_back({n, r});
  endtask

  task automatic send_evt();
    evt_times = ev;
    evt_valid = 1'b1;
    cyc(1);
    evt_valid = 1'b0;
  endtask

  task automatic wait_valid(input logic level, input string name);
    int k;
    k = 0;
    while (RD_VALID !== level && k < 200) begin
      cyc(1);
      k++;
    end
    check(name, 32'(RD_VALID), 32'(level));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (evt_busy !== 1'b0 && k < 200) begin
      cyc(1);
      k++;
    end
    check(name, 32'(evt_busy), 32'd0);
  endtask

  task automatic read_word();
    wait_valid(1'b1, "rd_wait_valid");
    RD_EN  = 1'b1;
    RD_CLK = 1'b1;
    wait_valid(1'b0, "rd_wait_release");
    RD_CLK = 1'b0;
    cyc(3);
  endtask

  initial begin
    // 1. reset
    cyc(3);
    check("rst_empty", 32'(RD_EMPTY), 32'd1);
    check("rst_valid", 32'(RD_VALID), 32'd0);
    check("rst_busy",  32'(evt_busy), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    check("rst_tuben", 32'(OTUBEN),   32'd0);
    check("rst_tuber", 32'(OTUBER),   32'd0);
    rst = 1'b0;
    cyc(2);

    // 2. two-hit event
    clr_ev(); set_hit(3, 8'h12); set_hit(17, 8'h40);
    push(8'd3, 8'h12); push(8'd17, 8'h40);
`ifdef TUBE_READOUT_TRAILER_EN
    push(8'hFF, 8'h02);
`endif
    send_evt();
    check("evt_empty_fall", 32'(RD_EMPTY), 32'd0);
    check("evt_busy_set",   32'(evt_busy), 32'd1);
    read_word();
    read_word();
`ifdef TUBE_READOUT_TRAILER_EN
    check("trl_pending_empty", 32'(RD_EMPTY), 32'd0);
    read_word();
`endif
    check("two_hit_empty", 32'(RD_EMPTY), 32'd1);
    wait_idle("two_hit_idle");

    // 3. event with no hits
    clr_ev();
    send_evt();
    cyc(2);
    check("nohit_busy",  32'(evt_busy), 32'd0);
    check("nohit_empty", 32'(RD_EMPTY), 32'd1);
    check("nohit_drop",  32'(drop_cnt), 32'd0);

    // 4. event dropped while half read
    clr_ev(); set_hit(0, 8'h05); set_hit(31, 8'h7F);
    push(8'd0, 8'h05); push(8'd31, 8'h7F);
`ifdef TUBE_READOUT_TRAILER_EN
    push(8'hFF, 8'h02);
`endif
    send_evt();
    read_word();
    clr_ev(); set_hit(5, 8'h33);
    send_evt();
    check("drop_cnt_1",   32'(drop_cnt), 32'd1);
    check("drop_busy",    32'(evt_busy), 32'd1);
    read_word();
`ifdef TUBE_READOUT_TRAILER_EN
    read_word();
`endif
    wait_idle("drop_evt_idle");

    // 5. RD_CLK without RD_EN, then a strobe landing in SCAN
    clr_ev(); set_hit(2, 8'h21); set_hit(20, 8'h44);
    push(8'd2, 8'h21); push(8'd20, 8'h44);
`ifdef TUBE_READOUT_TRAILER_EN
    push(8'hFF, 8'h02);
`endif
    send_evt();
    wait_valid(1'b1, "hold_wait_valid");
    RD_EN = 1'b0;
    repeat (4) begin
      RD_CLK = 1'b1; cyc(3);
      RD_CLK = 1'b0; cyc(3);
    end
    cyc(4);
    check("hold_valid", 32'(RD_VALID), 32'd1);
    check("hold_tuben", 32'(OTUBEN),   32'd2);
    check("hold_tuber", 32'(OTUBER),   32'h21);
    read_word();
    RD_EN = 1'b1;
    RD_CLK = 1'b1; cyc(3);
    RD_CLK = 1'b0; cyc(2);
    check("scan_strobe_ignored", 32'(RD_VALID), 32'd0);
    read_word();
`ifdef TUBE_READOUT_TRAILER_EN
    read_word();
`endif
    wait_idle("hold_evt_idle");
    check("drop_cnt_kept", 32'(drop_cnt), 32'd1);

    // 6. reset in READY with five hits pending
    clr_ev(); set_hit(1, 8'h11); set_hit(4, 8'h14); set_hit(9, 8'h19);
    set_hit(12, 8'h1C); set_hit(25, 8'h29);
    push(8'd1, 8'h11);
    send_evt();
    wait_valid(1'b1, "mid_rst_ready");
    rst = 1'b1;
    cyc(1);
    check("mid_rst_empty", 32'(RD_EMPTY), 32'd1);
    check("mid_rst_valid", 32'(RD_VALID), 32'd0);
    check("mid_rst_busy",  32'(evt_busy), 32'd0);
    check("mid_rst_drop",  32'(drop_cnt), 32'd0);
    rst = 1'b0;
    cyc(2);
    clr_ev(); set_hit(7, 8'h0A); set_hit(30, 8'h0B);
    push(8'd7, 8'h0A); push(8'd30, 8'h0B);
`ifdef TUBE_READOUT_TRAILER_EN
    push(8'hFF, 8'h02);
`endif
    send_evt();
    read_word();
    read_word();
`ifdef TUBE_READOUT_TRAILER_EN
    read_word();
`endif
    wait_idle("post_rst_idle");
    check("post_rst_empty", 32'(RD_EMPTY), 32'd1);
    cyc(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
